// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Hazard detection and forwarding-select unit for the pipelined
//               CPU. Tracks in-flight register writes across DEPTH post-decode
//               stages (stage 1 = EX, stage DEPTH = WB), raises the ID-stage
//               stall and registers the EX-stage operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int DEPTH    = 3,
    parameter int REG_W    = 5,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_is_load,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [SEL_W-1:0] inflight
);

    localparam logic [SEL_W-1:0] c_depth    = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] c_alu_lat  = SEL_W'(ALU_LAT);
    localparam logic [SEL_W-1:0] c_load_lat = SEL_W'(LOAD_LAT);
    localparam logic [SEL_W-1:0] c_two      = SEL_W'(2);

    // Tracked entries, index 1 is EX, index DEPTH is WB.
    logic [DEPTH:1]   r_v;
    logic [REG_W-1:0] r_dst [1:DEPTH];
    logic [SEL_W-1:0] r_rem [1:DEPTH];
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic [SEL_W-1:0] r_inflight;

    logic             w_hit_a;
    logic             w_hit_b;
    logic [SEL_W-1:0] w_k_a;
    logic [SEL_W-1:0] w_k_b;
    logic [SEL_W-1:0] w_rem_a;
    logic [SEL_W-1:0] w_rem_b;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;
    logic             w_stall;
    logic             w_advance;

    logic [DEPTH:1]   w_nv;
    logic [REG_W-1:0] w_ndst [1:DEPTH];
    logic [SEL_W-1:0] w_nrem [1:DEPTH];
    logic [SEL_W-1:0] w_cnt;

    // Youngest matching producer per source: scanning oldest to youngest so the lowest stage wins.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_k_a   = '0;
        w_k_b   = '0;
        w_rem_a = '0;
        w_rem_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_use_rs && (id_rs != '0) && r_v[k] && (r_dst[k] == id_rs)) begin
                w_hit_a = 1'b1;
                w_k_a   = SEL_W'(k);
                w_rem_a = r_rem[k];
            end
            if (id_use_rt && (id_rt != '0) && r_v[k] && (r_dst[k] == id_rt)) begin
                w_hit_b = 1'b1;
                w_k_b   = SEL_W'(k);
                w_rem_b = r_rem[k];
            end
        end
    end

    // Stall when a needed result is still two or more cycles away; flush kills the ID instruction.
    always_comb begin
        w_stall   = id_valid & ~flush &
                    ((w_hit_a & (w_rem_a >= c_two)) | (w_hit_b & (w_rem_b >= c_two)));
        w_advance = id_valid & ~w_stall & ~hold & ~flush;
        // The producer moves one stage by the time the consumer sits in EX; a WB match commits to the RF.
        w_sel_a   = (!w_hit_a || (w_k_a == c_depth)) ? '0 : w_k_a + SEL_W'(1);
        w_sel_b   = (!w_hit_b || (w_k_b == c_depth)) ? '0 : w_k_b + SEL_W'(1);
    end

    assign stall = w_stall;

    // Next entry state for an unfrozen edge: shift, decrement, insert or bubble, flush kills EX.
    always_comb begin
        w_nv      = '0;
        w_ndst[1] = id_dst;
        w_nrem[1] = id_is_load ? c_load_lat : c_alu_lat;
        w_nv[1]   = w_advance & id_wen & (id_dst != '0);
        for (int k = 2; k <= DEPTH; k++) begin
            w_nv[k]   = r_v[k-1] & ~(flush & (k == 2));
            w_ndst[k] = r_dst[k-1];
            w_nrem[k] = (r_rem[k-1] == '0) ? '0 : r_rem[k-1] - SEL_W'(1);
        end
        w_cnt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_cnt = w_cnt + SEL_W'(w_nv[k]);
        end
    end

    // Entry, select and occupancy registers; hold freezes all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v        <= '0;
            r_sel_a    <= '0;
            r_sel_b    <= '0;
            r_inflight <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dst[k] <= '0;
                r_rem[k] <= '0;
            end
        end else if (!hold) begin
            r_v        <= w_nv;
            r_inflight <= w_cnt;
            r_sel_a    <= w_advance ? w_sel_a : '0;
            r_sel_b    <= w_advance ? w_sel_b : '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dst[k] <= w_ndst[k];
                r_rem[k] <= w_nrem[k];
            end
        end
    end

    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire
